// File: rtl/decim_pkg.sv
// decim_pkg: shared constants and helpers for the decimating delay line.
//   MODE_PICK / MODE_MEAN : cfg_mode encodings
//   CFG_W                 : width of the cfg_log2 request field
//   clamp_log2()          : limits a requested log2 factor to the build maximum
package decim_pkg;

  localparam logic MODE_PICK = 1'b0;
  localparam logic MODE_MEAN = 1'b1;
  localparam int   CFG_W     = 4;

  function automatic logic [CFG_W-1:0] clamp_log2(input logic [CFG_W-1:0] req,
                                                   input int              max_log2);
    if (int'(req) > max_log2) return CFG_W'(max_log2);
    return req;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// valid_delay_line: DEPTH-entry shift register where each entry carries a
// valid bit. Shifts on en; flush clears the valid bits (data is left alone,
// it is never observed without its valid bit).
//   clk, rst_n  : clock, async active-low reset
//   en          : shift din in this edge
//   flush       : drop all entries this edge (wins over en)
//   din         : sample entering the line
//   dout        : oldest entry, i.e. the sample leaving on this edge
//   dout_valid  : dout really leaves this edge and held a sample
module valid_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0]            vld_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      vld_pipe <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else if (en) begin
      data_q[0]   <= din;
      vld_pipe[0] <= 1'b1;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i]   <= data_q[i-1];
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  // The tail entry is consumed by the same edge that shifts it out.
  assign dout       = data_q[DEPTH-1];
  assign dout_valid = en & ~flush & vld_pipe[DEPTH-1];

endmodule

// File: rtl/decim_delay_line.sv
// decim_delay_line: DEPTH-sample delay line feeding a 2^k decimator with
// pick (last sample of group) or mean (floor average of group) modes.
//   clk, rst_n : clock, async active-low reset
//   in_valid   : accept in_data this edge
//   in_data    : signed input sample
//   cfg_log2   : requested k (clamped to LOG2_MAX), latched at group start
//   cfg_mode   : MODE_PICK / MODE_MEAN, latched at group start
//   clear      : synchronous flush of delay line, counter and accumulator
//   out_valid  : one-cycle pulse when out_data updates
//   out_data   : decimated sample, held between pulses
module decim_delay_line
  import decim_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 3,
  parameter int LOG2_MAX = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CFG_W-1:0] cfg_log2,
  input  logic             cfg_mode,
  input  logic             clear,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  localparam int ACC_W = WIDTH + LOG2_MAX;
  localparam int CNT_W = (LOG2_MAX > 0) ? LOG2_MAX : 1;

  logic [WIDTH-1:0]        s;
  logic                    s_valid;

  logic [CNT_W-1:0]        cnt_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [CFG_W-1:0]        k_act_q;
  logic                    mode_act_q;

  logic                    grp_start;
  logic                    grp_last;
  logic [CFG_W-1:0]        k_cur;
  logic                    mode_cur;
  logic signed [ACC_W-1:0] s_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0]        cnt_mask;
  logic [WIDTH-1:0]        mean_val;

  valid_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dl (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (in_valid),
    .flush      (clear),
    .din        (in_data),
    .dout       (s),
    .dout_valid (s_valid)
  );

  // At group start the freshly sampled config governs this very sample,
  // so a k=0 group completes on the same edge it starts.
  always_comb begin
    grp_start = (cnt_q == '0);
    k_cur     = grp_start ? clamp_log2(cfg_log2, LOG2_MAX) : k_act_q;
    mode_cur  = grp_start ? cfg_mode : mode_act_q;
    s_ext     = ACC_W'(signed'(s));
    acc_sum   = grp_start ? s_ext : (acc_q + s_ext);
    cnt_mask  = ~({CNT_W{1'b1}} << k_cur);
    grp_last  = (cnt_q == cnt_mask);
    // Sum of 2^k WIDTH-bit samples shifted by k always fits back in WIDTH.
    mean_val  = WIDTH'(acc_sum >>> k_cur);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      k_act_q    <= '0;
      mode_act_q <= MODE_PICK;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else if (clear) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (s_valid) begin
        if (grp_start) begin
          k_act_q    <= k_cur;
          mode_act_q <= mode_cur;
        end
        acc_q <= acc_sum;
        if (grp_last) begin
          cnt_q     <= '0;
          out_valid <= 1'b1;
          out_data  <= (mode_cur == MODE_MEAN) ? mean_val : s;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_decim_delay_line.sv
// Scoreboard bench for decim_delay_line (WIDTH=8, DEPTH=3, LOG2_MAX=3).
// Stimulus tasks push hand-computed expected outputs tagged with the cycle
// they must appear in; a monitor pops on every out_valid pulse.
module tb_decim_delay_line;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = '0;
  logic [3:0] cfg_log2 = '0;
  logic       cfg_mode = 1'b0;
  logic       clear    = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;

  decim_delay_line #(.WIDTH(8), .DEPTH(3), .LOG2_MAX(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .cfg_log2  (cfg_log2),
    .cfg_mode  (cfg_mode),
    .clear     (clear),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest expectation, both value and cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: got out_data=%0h at cycle %0d, want no pulse", out_data, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(mon_e.val));
          check("out_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic acc(input logic [7:0] d, input bit e, input logic [7:0] ev);
    exp_t x;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    clear    = 1'b0;
    if (e) begin
      x.cyc = cyc + 1;
      x.val = ev;
      sb.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      clear    = 1'b0;
    end
  endtask

  task automatic flush(input logic v, input logic [7:0] d);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = v;
    in_data  = d;
  endtask

  // k=1 pick over 1..10: outputs 2,4,6 after accepts 5,7,9.
  task automatic run_case1(input bit gaps);
    for (int i = 1; i <= 10; i++) begin
      acc(8'(i), (i == 5 || i == 7 || i == 9), 8'(i - 3));
      if (gaps) idle((i % 2) + 1);
    end
  endtask

  logic [7:0] c4_in  [13] = '{8'd4, 8'd4, 8'd4, 8'd8, 8'd8, 8'd8, 8'd8,
                              8'd12, 8'd16, 8'd20, 8'd0, 8'd0, 8'd0};
  logic [7:0] c4_exp [13] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5,
                              8'd8, 8'd8, 8'd8, 8'd12, 8'd16, 8'd20};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100us");
    $fatal(1);
  end

  initial begin
    cfg_log2 = 4'd1;
    cfg_mode = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;

    // 1: k=1 pick, continuous
    run_case1(1'b0);
    idle(2);
    flush(1'b0, 8'd0);

    // 2: k=2 mean of -1..-4 -> floor(-2.5) = -3
    cfg_log2 = 4'd2;
    cfg_mode = 1'b1;
    acc(8'hFF, 1'b0, 8'h00);
    acc(8'hFE, 1'b0, 8'h00);
    acc(8'hFD, 1'b0, 8'h00);
    acc(8'hFC, 1'b0, 8'h00);
    acc(8'h00, 1'b0, 8'h00);
    acc(8'h00, 1'b0, 8'h00);
    acc(8'h00, 1'b1, 8'hFD);
    idle(2);
    flush(1'b0, 8'd0);

    // 3: case 1 with idle gaps
    cfg_log2 = 4'd1;
    cfg_mode = 1'b0;
    run_case1(1'b1);
    idle(2);
    flush(1'b0, 8'd0);

    // 4: k=2 mean, then k=0 from the next group on
    cfg_log2 = 4'd2;
    cfg_mode = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i == 5) cfg_log2 = 4'd0;
      acc(c4_in[i], (i >= 6), c4_exp[i]);
    end
    idle(3);
    check("held_after_idle", 32'(out_data), 32'd20);
    flush(1'b0, 8'd0);
    idle(1);
    check("held_after_clear", 32'(out_data), 32'd20);
    check("valid_after_clear", 32'(out_valid), 32'd0);

    // 5: clear with simultaneous accept mid-group; cfg 9 clamps to k=3
    cfg_log2 = 4'd9;
    cfg_mode = 1'b1;
    for (int i = 1; i <= 5; i++) acc(8'(i), 1'b0, 8'h00);
    flush(1'b1, 8'd99);
    for (int j = 1; j <= 12; j++) acc(8'(9 + j), (j == 11), 8'd13);
    idle(2);
    flush(1'b0, 8'd0);

    // 6: async reset mid-group, then replay case 1
    cfg_log2 = 4'd1;
    cfg_mode = 1'b0;
    for (int i = 1; i <= 6; i++) acc(8'(i), (i == 5), 8'd2);
    @(negedge clk);
    in_valid = 1'b0;
    check("held_before_rst", 32'(out_data), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_data", 32'(out_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_case1(1'b0);
    idle(4);

    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
